// File: rtl/collatz_pkg.sv
// Shared types for the Collatz engine.
//   state_t : controller states. IDLE waits for start, RUN iterates one step
//             per clock, DONE is the single completion cycle.
package collatz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/collatz_if.sv
// Request/result bundle between a Collatz engine and its requester.
//   start, fast, seed          : request (master -> slave)
//   busy, done                 : handshake status (slave -> master)
//   value, steps, peak         : run results, held until the next accepted start
//   ovf, tmo, zero             : termination flags (overflow, step timeout, zero seed)
interface collatz_if #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
);
    logic             start;
    logic             fast;
    logic [WIDTH-1:0] seed;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] value;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] peak;
    logic             ovf;
    logic             tmo;
    logic             zero;

    modport master (
        output start, fast, seed,
        input  busy, done, value, steps, peak, ovf, tmo, zero
    );

    modport slave (
        input  start, fast, seed,
        output busy, done, value, steps, peak, ovf, tmo, zero
    );
endinterface

// File: rtl/collatz_step.sv
// Combinational single Collatz step.
//   x       : current value
//   mode    : 1 = shortcut, an odd step yields (3x+1)/2
//   x_next  : value after this step (meaningless when ovf_int is set)
//   is_one  : x has reached 1
//   ovf_int : 3x+1 does not fit in WIDTH bits (odd x only)
//   inc     : standard-step equivalents taken by this step (1 or 2)
//   t_peak  : 3x+1 on odd steps, 0 on even steps (peak candidate)
module collatz_step #(
    parameter int WIDTH = 20
) (
    input  logic [WIDTH-1:0] x,
    input  logic             mode,
    output logic [WIDTH-1:0] x_next,
    output logic             is_one,
    output logic             ovf_int,
    output logic [1:0]       inc,
    output logic [WIDTH-1:0] t_peak
);

    localparam logic [WIDTH+1:0] ONE_EXT = (WIDTH+2)'(1);

    // Two guard bits hold 3x+1 for any WIDTH-bit x without wrapping.
    logic [WIDTH+1:0] t;
    logic             odd;

    always_comb begin
        odd     = x[0];
        t       = {2'b00, x} + {1'b0, x, 1'b0} + ONE_EXT;
        is_one  = (x == WIDTH'(1));
        ovf_int = odd && (t[WIDTH+1:WIDTH] != 2'b00);
        if (odd) begin
            inc    = mode ? 2'd2 : 2'd1;
            // Without overflow t[WIDTH] is 0, so t[WIDTH:1] is exactly t/2.
            x_next = mode ? t[WIDTH:1] : t[WIDTH-1:0];
            t_peak = t[WIDTH-1:0];
        end else begin
            inc    = 2'd1;
            x_next = {1'b0, x[WIDTH-1:1]};
            t_peak = '0;
        end
    end

endmodule

// File: rtl/collatz_engine.sv
// Collatz-sequence engine: accepts a seed, iterates one step per clock until
// the value reaches 1, then pulses done with step count, peak and flags.
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : collatz_if.slave (start/fast/seed in; busy/done/value/steps/peak/
//           ovf/tmo/zero out, all registered)
module collatz_engine
    import collatz_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    collatz_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             tmo_q, tmo_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] x_next;
    logic             is_one;
    logic             ovf_int;
    logic [1:0]       inc;
    logic [WIDTH-1:0] t_peak;
    logic [CNT_W:0]   steps_sum;

    // Step counter add with carry-out; the carry means the sum passed
    // 2^CNT_W-1, i.e. the step limit is hit.
    function automatic logic [CNT_W:0] step_add(input logic [CNT_W-1:0] s,
                                                input logic [1:0]       i);
        return {1'b0, s} + {{(CNT_W-1){1'b0}}, i};
    endfunction

    collatz_step #(.WIDTH(WIDTH)) u_step (
        .x       (x_q),
        .mode    (mode_q),
        .x_next  (x_next),
        .is_one  (is_one),
        .ovf_int (ovf_int),
        .inc     (inc),
        .t_peak  (t_peak)
    );

    assign steps_sum = step_add(steps_q, inc);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        steps_d = steps_q;
        peak_d  = peak_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.seed;
                    steps_d = '0;
                    peak_d  = bus.seed;
                    mode_d  = bus.fast;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    zero_d  = (bus.seed == '0);
                    state_d = (bus.seed == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (is_one) begin
                    state_d = DONE;
                end else if (ovf_int) begin
                    ovf_d   = 1'b1;
                    state_d = DONE;
                end else if (steps_sum[CNT_W]) begin
                    tmo_d   = 1'b1;
                    steps_d = '1;
                    state_d = DONE;
                end else begin
                    x_d     = x_next;
                    steps_d = steps_sum[CNT_W-1:0];
                    if (t_peak > peak_q) begin
                        peak_d = t_peak;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // busy covers the RUN and DONE cycles of a real run; a zero seed
        // goes IDLE->DONE and never raises it. done trails the DONE state so
        // it lands together with busy falling.
        busy_d = (state_d == RUN) || (state_q == RUN);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            steps_q <= '0;
            peak_q  <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            steps_q <= steps_d;
            peak_q  <= peak_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.value = x_q;
    assign bus.steps = steps_q;
    assign bus.peak  = peak_q;
    assign bus.ovf   = ovf_q;
    assign bus.tmo   = tmo_q;
    assign bus.zero  = zero_q;

endmodule

// File: tb/tb_collatz_engine.sv
// Scoreboard bench for collatz_engine: three instances (20/16, 8/16, 20/4)
// share clock and reset; expected results come from a plain-arithmetic
// Collatz model and are compared by a monitor whenever done pulses.
module tb_collatz_engine;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    longint cyc   = 0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    collatz_if #(.WIDTH(20), .CNT_W(16)) bus0 ();
    collatz_if #(.WIDTH(8),  .CNT_W(16)) bus1 ();
    collatz_if #(.WIDTH(20), .CNT_W(4))  bus2 ();

    collatz_engine #(.WIDTH(20), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    collatz_engine #(.WIDTH(8),  .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    collatz_engine #(.WIDTH(20), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        longint value;
        longint steps;
        longint peak;
        longint ovf;
        longint tmo;
        longint zero;
        longint lat;
        longint e0;
    } exp_t;

    typedef struct {
        longint busy;
        longint done;
        longint value;
        longint steps;
        longint peak;
        longint ovf;
        longint tmo;
        longint zero;
    } obs_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // Reference: walk the sequence with ordinary integers. Each loop pass is
    // one RUN cycle; done appears one cycle after the last RUN cycle.
    function automatic exp_t model(longint seed, bit fast, int w, int cw);
        exp_t   r;
        longint x, maxv, smax, t, nx, pk, inc, n;
        r    = '{default: 0};
        maxv = (longint'(1) << w) - 1;
        smax = (longint'(1) << cw) - 1;
        x    = seed;
        r.peak = seed;
        if (seed == 0) begin
            r.zero = 1;
            r.lat  = 1;
            return r;
        end
        n = 0;
        while (1) begin
            n++;
            if (x == 1) break;
            if (x % 2 == 1) begin
                t = 3 * x + 1;
                if (t > maxv) begin
                    r.ovf = 1;
                    break;
                end
                inc = fast ? 2 : 1;
                nx  = fast ? t / 2 : t;
                pk  = t;
            end else begin
                nx  = x / 2;
                inc = 1;
                pk  = 0;
            end
            if (r.steps + inc > smax) begin
                r.tmo   = 1;
                r.steps = smax;
                break;
            end
            x = nx;
            r.steps += inc;
            if (pk > r.peak) r.peak = pk;
        end
        r.value = x;
        r.lat   = n + 1;
        return r;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic obs_t observe(int d);
        obs_t o;
        case (d)
            0: o = '{longint'(bus0.busy), longint'(bus0.done), longint'(bus0.value), longint'(bus0.steps),
                     longint'(bus0.peak), longint'(bus0.ovf), longint'(bus0.tmo), longint'(bus0.zero)};
            1: o = '{longint'(bus1.busy), longint'(bus1.done), longint'(bus1.value), longint'(bus1.steps),
                     longint'(bus1.peak), longint'(bus1.ovf), longint'(bus1.tmo), longint'(bus1.zero)};
            default: o = '{longint'(bus2.busy), longint'(bus2.done), longint'(bus2.value), longint'(bus2.steps),
                     longint'(bus2.peak), longint'(bus2.ovf), longint'(bus2.tmo), longint'(bus2.zero)};
        endcase
        return o;
    endfunction

    function automatic int qsize(int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic set_in(int d, bit st, longint sd, bit f);
        case (d)
            0: begin bus0.start = st; bus0.seed = 20'(sd); bus0.fast = f; end
            1: begin bus1.start = st; bus1.seed = 8'(sd);  bus1.fast = f; end
            default: begin bus2.start = st; bus2.seed = 20'(sd); bus2.fast = f; end
        endcase
    endtask

    task automatic set_start(int d, bit st);
        case (d)
            0:       bus0.start = st;
            1:       bus1.start = st;
            default: bus2.start = st;
        endcase
    endtask

    task automatic push_exp(int d, exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic score(int d, obs_t o);
        exp_t  e;
        bit    have;
        string p;
        have = 1'b0;
        p = $sformatf("dut%0d", d);
        case (d)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("FAIL %s.unexpected_done: got done=1, expected done=0", p);
            return;
        end
        chk({p, ".value"},   o.value, e.value);
        chk({p, ".steps"},   o.steps, e.steps);
        chk({p, ".peak"},    o.peak,  e.peak);
        chk({p, ".ovf"},     o.ovf,   e.ovf);
        chk({p, ".tmo"},     o.tmo,   e.tmo);
        chk({p, ".zero"},    o.zero,  e.zero);
        chk({p, ".busy_at_done"}, o.busy, 0);
        chk({p, ".latency"}, cyc - e.e0, e.lat);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            obs_t o;
            o = observe(d);
            if (o.done == 1) score(d, o);
        end
    end

    task automatic check_idle(int d, string tag);
        obs_t  o;
        string p;
        o = observe(d);
        p = $sformatf("dut%0d.%s", d, tag);
        chk({p, ".busy"},  o.busy,  0);
        chk({p, ".done"},  o.done,  0);
        chk({p, ".value"}, o.value, 0);
        chk({p, ".steps"}, o.steps, 0);
        chk({p, ".peak"},  o.peak,  0);
        chk({p, ".ovf"},   o.ovf,   0);
        chk({p, ".tmo"},   o.tmo,   0);
        chk({p, ".zero"},  o.zero,  0);
    endtask

    // Waits for the run's done, occasionally pulsing start while busy; such
    // pulses must be ignored by the engine.
    task automatic wait_done(int d);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            set_start(d, 1'b0);
            if (qsize(d) == 0) begin
                ok = 1'b1;
                break;
            end
            if (observe(d).busy == 1 && $urandom_range(0, 15) == 0) set_start(d, 1'b1);
        end
        set_start(d, 1'b0);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL dut%0d.timeout: no done within 3000 cycles, expected a done pulse", d);
            case (d)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
    endtask

    task automatic start_run(int d, longint seed, bit fast);
        exp_t e;
        int   w, cw;
        w  = (d == 1) ? 8 : 20;
        cw = (d == 2) ? 4 : 16;
        e  = model(seed, fast, w, cw);
        @(negedge clk);
        set_in(d, 1'b1, seed, fast);
        @(posedge clk);
        #1;
        e.e0 = cyc;
        push_exp(d, e);
        chk($sformatf("dut%0d.busy_after_start", d), observe(d).busy, (seed != 0) ? 1 : 0);
        @(negedge clk);
        // Scramble seed/fast while the run is in flight.
        set_in(d, 1'b0, longint'($urandom), ~fast);
        wait_done(d);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle(d, "reset");
        rst_n = 1'b1;

        // Directed runs.
        start_run(0, 6, 1'b0);
        start_run(0, 6, 1'b1);
        start_run(0, 27, 1'b0);
        start_run(0, 0, 1'b0);
        start_run(0, 1, 1'b0);
        start_run(0, 1, 1'b1);
        start_run(1, 27, 1'b0);
        start_run(1, 27, 1'b1);
        start_run(2, 27, 1'b0);
        start_run(2, 49152, 1'b1);
        start_run(2, 0, 1'b1);

        // Randomised runs on each instance.
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 15; k++) begin
                longint sd;
                longint maxv;
                maxv = (d == 1) ? 255 : 1048575;
                if ($urandom_range(0, 3) == 0) sd = longint'($urandom_range(0, 40));
                else                           sd = longint'($urandom_range(1, 32'(maxv)));
                start_run(d, sd, 1'($urandom_range(0, 1)));
            end
        end

        // Reset in the middle of a long run: no done, everything cleared.
        @(negedge clk);
        set_in(0, 1'b1, 27, 1'b0);
        @(negedge clk);
        set_in(0, 1'b0, 0, 1'b0);
        repeat (30) @(negedge clk);
        chk("dut0.busy_before_reset", observe(0).busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle(0, "midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle(0, "after_reset");
        start_run(0, 6, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collatz_engine.md
# collatz_engine

Parametrised Collatz-sequence engine: the next generation of the hold/in/odd/even controller, now with an integrated datapath. It accepts a seed, iterates odd (3x+1) and even (x/2) steps one per clock until the value reaches 1, and reports step count, peak value and error flags. It generalises the datapath width and adds a shortcut mode, overflow detection, step-count timeout and a start/busy/done handshake.

## Interface
- WIDTH, 20: value datapath width (seed, value, peak).
- CNT_W, 16: step counter width; maximum count STEP_MAX = 2^CNT_W-1.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- fast  in  1  shortcut mode, latched with start: odd step computes (3x+1)/2 in one cycle.
- seed  in  WIDTH  starting value, latched with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- value  out  WIDTH  current or final x.
- steps  out  CNT_W  Collatz steps taken (standard-step equivalents).
- peak  out  WIDTH  largest value reached, including the 3x+1 intermediate in fast mode.
- ovf  out  1  3x+1 exceeded 2^WIDTH-1.
- tmo  out  1  step counter limit hit.
- zero  out  1  seed was 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → x<=seed, steps<=0, peak<=seed, flags<=0, mode<=fast, → RUN. If seed=0: zero<=1, → DONE directly.
- RUN, evaluated in this priority order, one action per cycle:
  - x==1 → DONE.
  - x odd: t=3x+1 computed in WIDTH+2 bits. If t>2^WIDTH-1: ovf<=1, x unchanged, → DONE. Otherwise inc=2 if mode else 1, and x<=t>>1 if mode else t.
  - x even: x<=x>>1, inc=1.
  - Timeout check on any step: if steps+inc > STEP_MAX, tmo<=1, steps<=STEP_MAX, x unchanged, → DONE. Otherwise steps<=steps+inc.
  - Peak: peak<=max(peak, t) on odd steps; even steps never raise it.
- DONE: done=1 for this one cycle, busy=0. Always → IDLE. start in DONE is ignored.
- value, steps, peak and flags hold after completion until the next accepted start.
- start while busy: ignored. seed/fast changes while busy: no effect.

## Timing
- Reset values: state IDLE; busy, done, value, steps, peak, ovf, tmo, zero are all 0.
- Start sampled at edge E0 → busy=1 after E0.
- A run of C RUN cycles ends with done high after edge E0+C+1.
  - Standard mode: C = steps+1.
  - Fast mode: C = even steps + odd steps + 1.
- seed=1: done after E0+2, steps=0. seed=0: done after E0+1, zero=1, busy stays 0.
- Back-to-back runs: earliest next accept is the IDLE cycle after done.
- rst_n low mid-run: immediate return to IDLE, all outputs 0, no done pulse.
- Outputs are all registered; no combinational path from inputs to outputs.

## Structure
- Package collatz_pkg: state enum (IDLE, RUN, DONE).
- Sub-module collatz_step (combinational, parametrised by WIDTH):
  - Inputs: x, mode.
  - Outputs: x_next, is_one, ovf_int, inc, t_peak.
- Top: FSM, x/steps/peak/flag registers, saturation compare.

## Test plan
- WIDTH=20, standard, seed=6 → steps=8, peak=16, value=1, done after E0+10, flags 0.
- WIDTH=20, fast, seed=6 → steps=8, peak=16, done after E0+8. Seed=27 standard → steps=111, peak=9232.
- WIDTH=8, seed=27 → ovf=1 at x=107, value=107, steps=11, peak=214.
- CNT_W=4, seed=27 standard → tmo=1, steps=15, done pulse. Fast mode with steps=14 and an odd x → tmo, steps=15.
- seed=0 → zero=1, done after E0+1. seed=1 → steps=0, done after E0+2.
- start pulsed while busy: ignored, results unchanged. rst_n low mid-run: no done, outputs 0, new start then runs cleanly.
